// File: rtl/uart_rx_core.sv
// UART 8N1 receiver feeding a one-byte valid/ready buffer; byte valid one cycle after the stop-bit sample.
// Never stalls on rx_ready: a byte completing into a full, unaccepted buffer is dropped with an overrun pulse.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        rx_s1;
  logic        rxs;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        dlv_q;

  logic        half_tick;
  logic        bit_tick;
  logic        timer_clr;
  logic        idx_clr;
  logic        shift_en;
  logic        stop_ok;
  logic        stop_bad;

  assign half_tick = (timer == HALF_M1);
  assign bit_tick  = (timer == BIT_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rxs   <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxs) state_nxt = START;
      START:     if (half_tick) state_nxt = rxs ? IDLE : DATA;
      DATA:      if (bit_tick && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:      if (bit_tick) state_nxt = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    timer_clr = 1'b0;
    idx_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        timer_clr = 1'b1;
        busy      = 1'b0;
      end
      START: begin
        if (half_tick) begin
          timer_clr = 1'b1;
          idx_clr   = 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          timer_clr = 1'b1;
          stop_ok   = rxs;
          stop_bad  = !rxs;
        end
      end
      WAIT_HIGH: timer_clr = 1'b1;
      default:   timer_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      dlv_q     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      timer     <= timer_clr ? 16'd0 : timer + 16'd1;
      dlv_q     <= stop_ok;
      frame_err <= stop_bad;
      if (idx_clr) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      // LSB arrives first, so each new bit enters at the top and walks down.
      if (shift_en) begin
        shift <= {rxs, shift[7:1]};
      end
    end
  end

  // shift is untouched until the next frame's first data bit, so it is still valid one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (dlv_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at CLKS_PER_BIT=16: table of frames plus hand-built corner sequences.
module tb_uart_rx_core;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_core #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected nothing queued", name, rx_data);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'd0, rx_data}, {24'd0, e});
    end
  endtask

  task automatic wait_valid(input string name, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  // Starts right after a posedge; leaves the line at the stop-bit value.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    last_start = cyc + 1;
    uart_rx = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = d[i];
      repeat (C) @(posedge clk);
    end
    #1 uart_rx = stop_bit;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic accept(input string name);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check(name, {31'd0, rx_valid}, 32'd0);
  endtask

  vec_t vecs[6];
  int b_rise, b_ferr, b_ovr;

  initial begin
    vecs[0] = '{data: 8'h00, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 0};
    vecs[1] = '{data: 8'hFF, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 0};
    vecs[2] = '{data: 8'h5A, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'h5A, exp_ferr: 0};
    vecs[3] = '{data: 8'h80, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 0};
    vecs[4] = '{data: 8'hE7, stop_bit: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1};
    vecs[5] = '{data: 8'h01, stop_bit: 1'b1, exp_valid: 1'b1, exp_data: 8'h01, exp_ferr: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // A5 held with rx_ready low, exact rx_valid latency
    b_rise = rise_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid("a5_valid", 20);
    check("a5_latency", rise_cyc - last_start, 32'd155);
    check("a5_rise", rise_cnt - b_rise, 32'd1);
    repeat (10) @(negedge clk);
    check("a5_hold_valid", {31'd0, rx_valid}, 32'd1);
    pop_check("a5_data");
    accept("a5_clr");

    // table of single frames
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      b_rise = rise_cnt;
      b_ferr = ferr_cnt;
      if (vecs[k].exp_valid) exp_q.push_back(vecs[k].exp_data);
      send_frame(vecs[k].data, vecs[k].stop_bit);
      uart_rx = 1'b1;
      repeat (6) @(negedge clk);
      check($sformatf("vec%0d_rise", k), rise_cnt - b_rise, {31'd0, vecs[k].exp_valid});
      check($sformatf("vec%0d_ferr", k), ferr_cnt - b_ferr, vecs[k].exp_ferr);
      check($sformatf("vec%0d_valid", k), {31'd0, rx_valid}, {31'd0, vecs[k].exp_valid});
      if (vecs[k].exp_valid) pop_check($sformatf("vec%0d_data", k));
      accept($sformatf("vec%0d_clr", k));
    end

    // start-bit glitch, then 3C
    @(posedge clk);
    #1;
    b_rise = rise_cnt;
    b_ferr = ferr_cnt;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_rise", rise_cnt - b_rise, 32'd0);
    check("glitch_ferr", ferr_cnt - b_ferr, 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_valid("3c_valid", 20);
    pop_check("3c_data");
    accept("3c_clr");

    // bad stop bit with line held low
    @(posedge clk);
    #1;
    b_rise = rise_cnt;
    b_ferr = ferr_cnt;
    send_frame(8'h55, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("brk_busy_low", {31'd0, busy}, 32'd1);
    #1 uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    check("brk_busy_idle", {31'd0, busy}, 32'd0);
    check("brk_ferr", ferr_cnt - b_ferr, 32'd1);
    check("brk_rise", rise_cnt - b_rise, 32'd0);
    check("brk_valid", {31'd0, rx_valid}, 32'd0);

    // back-to-back 01, 02 with no acceptance: second byte dropped
    @(posedge clk);
    #1;
    b_ovr = ovr_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    repeat (6) @(negedge clk);
    check("ovr_cnt", ovr_cnt - b_ovr, 32'd1);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    pop_check("ovr_data");
    accept("ovr_clr");

    // FF then 00 with rx_ready high exactly on the second delivery edge
    @(posedge clk);
    #1;
    b_ovr = ovr_cnt;
    b_rise = rise_cnt;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'h00);
    fork
      send_frame(8'h00, 1'b1);
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        pop_check("sim_first_data");
        repeat (135) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("sim_ovr", ovr_cnt - b_ovr, 32'd0);
    check("sim_valid", {31'd0, rx_valid}, 32'd1);
    check("sim_rise", rise_cnt - b_rise, 32'd1);
    pop_check("sim_second_data");
    accept("sim_clr");

    // reset in the middle of C3 with a stale byte pending
    @(posedge clk);
    #1;
    send_frame(8'h12, 1'b1);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mrst_data", {24'd0, rx_data}, 32'h00);
        check("mrst_valid", {31'd0, rx_valid}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_ferr", {31'd0, frame_err}, 32'd0);
        check("mrst_ovr", {31'd0, overrun}, 32'd0);
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    b_rise = rise_cnt;
    b_ferr = ferr_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_valid("7e_valid", 20);
    check("7e_rise", rise_cnt - b_rise, 32'd1);
    check("7e_ferr", ferr_cnt - b_ferr, 32'd0);
    pop_check("7e_data");
    accept("7e_clr");

    check("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per bit (100 MHz / 115200); legal range 8..65535.
REQ-002 clk  input  1  system clock; sole clock, all state on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 uart_rx  input  1  serial line, asynchronous to clk, idle high, 8N1, LSB first.
REQ-005 rx_data  output  8  received byte, valid while rx_valid=1.
REQ-006 rx_valid  output  1  byte available; held until accepted.
REQ-007 rx_ready  input  1  consumer accept; transfer when rx_valid&rx_ready on a rising edge.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: byte completed while buffer full and not being accepted.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 uart_rx passes a 2-flop synchronizer, both flops reset to 1; all logic below uses the synchronized value rxs.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; one bit-timer counter (16 bit) and one 3-bit bit index.
REQ-013 IDLE: rxs=0 -> START, timer cleared; else stay.
REQ-014 START: when timer reaches CLKS_PER_BIT/2-1 (integer divide), sample rxs; 0 -> DATA, timer cleared, index=0; 1 -> IDLE (glitch rejected, no flags).
REQ-015 DATA: when timer reaches CLKS_PER_BIT-1, sample rxs into shift register MSB, shift right (LSB first), timer cleared; after index 7 -> STOP.
REQ-016 STOP: when timer reaches CLKS_PER_BIT-1, sample rxs; 1 -> deliver byte, IDLE; 0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rxs=1, then IDLE (break/stuck-low line produces exactly one frame_err).
REQ-018 Delivery: rx_data loaded and rx_valid set on the edge following the stop sample; rx_data stable while rx_valid=1.
REQ-019 Acceptance: rx_valid&rx_ready clears rx_valid next edge unless a delivery occurs the same cycle.
REQ-020 Simultaneous delivery and acceptance: new byte loaded, rx_valid stays 1, no overrun.
REQ-021 Delivery with rx_valid=1 and rx_ready=0: new byte dropped, old byte retained, overrun pulses one cycle.
REQ-022 Stop-bit sample occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first edge sampling uart_rx low in the first synchronizer flop; rx_valid high one cycle later.
REQ-023 Receiver never stalls on rx_ready; next start bit detected in IDLE regardless of buffer state.
REQ-024 frame_err and overrun never assert in the same cycle as each other for different frames; both are registered outputs.

Reset
REQ-025 rst=1 at a rising edge: FSM -> IDLE, timer/index=0, shift register=0, synchronizer flops=1.
REQ-026 Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
REQ-027 Reset mid-frame abandons the frame with no flags; after release, a line still low is treated as a new start bit only after rxs=1 then 0 is not required -- IDLE with rxs=0 enters START immediately.

Verification (bench uses CLKS_PER_BIT=16, 10 ns clk)
REQ-028 Send 8'hA5 with rx_ready=0 -> rx_valid rises at 2+8+144+1 cycles after start edge, rx_data=8'hA5, held until rx_ready=1, then rx_valid=0 next cycle.
REQ-029 Start-bit glitch low for 4 cycles -> returns IDLE, no rx_valid, no frame_err; following 8'h3C received correctly.
REQ-030 Send 8'h55 with stop bit forced low, line low 40 further cycles -> one frame_err pulse, no rx_valid, busy high until line returns high.
REQ-031 Back-to-back 8'h01 then 8'h02, rx_ready=0 -> rx_data=8'h01 retained, one overrun pulse at second delivery.
REQ-032 Back-to-back 8'hFF then 8'h00, rx_ready pulsed in delivery cycle of second byte -> rx_data=8'h00, rx_valid stays 1, no overrun.
REQ-033 rst asserted mid-DATA of 8'hC3 -> all outputs at reset values next cycle; following 8'h7E received correctly.
